// File: rtl/scan_decoder.sv
// Registered N-to-2^N decoder with one-hot, thermometer and timed auto-scan modes.
// Every output comes straight from a flop; the scan index advances after DIV enabled dwell edges.
module scan_decoder #(
  parameter int N          = 3,
  parameter int DIV        = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [N-1:0]        sel,
  output logic [(1<<N)-1:0]   d,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int W  = 1 << N;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [W-1:0]  POL     = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

  typedef enum logic [1:0] {
    MODE_DECODE = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  mode_t          mode_cur;
  logic [W-1:0]   d_reg;
  logic [N-1:0]   idx_reg;
  logic           wrap_reg;
  logic [CW-1:0]  cnt_reg;

  logic [N-1:0]   idx_next;
  logic [W-1:0]   sel_onehot;
  logic [W-1:0]   sel_therm;
  logic [W-1:0]   idx_onehot;
  logic [W-1:0]   next_onehot;

  assign mode_cur = mode_t'(mode);
  assign idx_next = idx_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_code
      assign sel_onehot[gi]  = (int'(sel) == gi);
      assign sel_therm[gi]   = (gi <= int'(sel));
      assign idx_onehot[gi]  = (int'(idx_reg) == gi);
      assign next_onehot[gi] = (int'(idx_next) == gi);
    end
  endgenerate

  // d_reg holds the post-polarity value so reset and idle states are inverted too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg  <= '0;
      d_reg    <= POL;
      wrap_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (!en) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      cnt_reg  <= '0;
      case (mode_cur)
        MODE_DECODE: begin
          idx_reg <= sel;
          d_reg   <= sel_onehot ^ POL;
        end
        MODE_THERM: begin
          idx_reg <= sel;
          d_reg   <= sel_therm ^ POL;
        end
        MODE_SCAN: begin
          if (cnt_reg == CNT_MAX) begin
            idx_reg  <= idx_next;
            d_reg    <= next_onehot ^ POL;
            wrap_reg <= (idx_reg == {N{1'b1}});
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            d_reg   <= idx_onehot ^ POL;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign d    = d_reg;
  assign idx  = idx_reg;
  assign wrap = wrap_reg;

endmodule
